// File: rtl/hms_time_cnt.sv
// ============================================================================
// hms_time_cnt : hh:mm:ss timekeeping core with button-driven set-mode FSM.
// Optional alarm compare/edit enabled by macro HMS_ALARM_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module hms_time_cnt #(
   parameter int HOUR_MAX = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_mode,
   input  logic       i_inc,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [5:0] o_hour,
   output logic [5:0] o_six_dp,
   output logic       o_day_wrap,
   output logic       o_alarm
);

   localparam logic [5:0] SEC_LAST  = 6'd59;
   localparam logic [5:0] HOUR_LAST = 6'(HOUR_MAX - 1);

   typedef enum logic [2:0] {
      ST_CLOCK        = 3'd0,
      ST_SET_SEC      = 3'd1,
      ST_SET_MIN      = 3'd2,
      ST_SET_HOUR     = 3'd3,
      ST_SET_ALM_MIN  = 3'd4,
      ST_SET_ALM_HOUR = 3'd5
   } state_t;

   state_t     state, state_next;
   logic [5:0] sec, min, hour;
   logic       day_wrap;
   logic       inc_en;

   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
      return (v == last) ? 6'd0 : v + 6'd1;
   endfunction

   // A mode press takes precedence over a simultaneous increment press.
   assign inc_en = i_inc & ~i_mode;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_CLOCK;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      o_six_dp   = 6'b000000;
      case (state)
         ST_CLOCK:    if (i_mode) state_next = ST_SET_SEC;
         ST_SET_SEC: begin
            o_six_dp = 6'b000011;
            if (i_mode) state_next = ST_SET_MIN;
         end
         ST_SET_MIN: begin
            o_six_dp = 6'b001100;
            if (i_mode) state_next = ST_SET_HOUR;
         end
         ST_SET_HOUR: begin
            o_six_dp = 6'b110000;
`ifdef HMS_ALARM_EN
            if (i_mode) state_next = ST_SET_ALM_MIN;
`else
            if (i_mode) state_next = ST_CLOCK;
`endif
         end
`ifdef HMS_ALARM_EN
         ST_SET_ALM_MIN: begin
            o_six_dp = 6'b001100;
            if (i_mode) state_next = ST_SET_ALM_HOUR;
         end
         ST_SET_ALM_HOUR: begin
            o_six_dp = 6'b110000;
            if (i_mode) state_next = ST_CLOCK;
         end
`endif
         default: state_next = ST_CLOCK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sec      <= 6'd0;
         min      <= 6'd0;
         hour     <= 6'd0;
         day_wrap <= 1'b0;
      end else begin
         day_wrap <= 1'b0;
         case (state)
            ST_CLOCK: if (i_tick) begin
               sec <= wrap_inc(sec, SEC_LAST);
               if (sec == SEC_LAST) begin
                  min <= wrap_inc(min, SEC_LAST);
                  if (min == SEC_LAST) begin
                     hour <= wrap_inc(hour, HOUR_LAST);
                     if (hour == HOUR_LAST) day_wrap <= 1'b1;
                  end
               end
            end
            ST_SET_SEC:  if (inc_en) sec  <= wrap_inc(sec, SEC_LAST);
            ST_SET_MIN:  if (inc_en) min  <= wrap_inc(min, SEC_LAST);
            ST_SET_HOUR: if (inc_en) hour <= wrap_inc(hour, HOUR_LAST);
            default: ;
         endcase
      end
   end

   assign o_day_wrap = day_wrap;

`ifdef HMS_ALARM_EN
   logic [5:0] alm_min, alm_hour;
   logic       alarm;

   always_ff @(posedge clk) begin
      if (rst) begin
         alm_min  <= 6'd0;
         alm_hour <= 6'd0;
         alarm    <= 1'b0;
      end else begin
         alarm <= (state == ST_CLOCK) && (hour == alm_hour) && (min == alm_min);
         if (inc_en && state == ST_SET_ALM_MIN)  alm_min  <= wrap_inc(alm_min, SEC_LAST);
         if (inc_en && state == ST_SET_ALM_HOUR) alm_hour <= wrap_inc(alm_hour, HOUR_LAST);
      end
   end

   // While editing the alarm, the display shows the alarm fields instead of time.
   always_comb begin
      o_sec  = sec;
      o_min  = min;
      o_hour = hour;
      if (state == ST_SET_ALM_MIN || state == ST_SET_ALM_HOUR) begin
         o_sec  = 6'd0;
         o_min  = alm_min;
         o_hour = alm_hour;
      end
   end

   assign o_alarm = alarm;
`else
   assign o_sec   = sec;
   assign o_min   = min;
   assign o_hour  = hour;
   assign o_alarm = 1'b0;
`endif

endmodule

`default_nettype wire
